// File: rtl/burst_memory_responder.sv
// Memory-side responder for the processor memory interface: a word-addressed RAM
// based at start_addr that serves single-word and 4/8/16-beat bursts.
module burst_memory_responder #(
   parameter int data_width = 32,
   parameter int address_width = 32,
   parameter int depth = 1048576,
   parameter logic [address_width-1:0] start_addr = 'h80020000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [address_width-1:0] address,
   input  logic [data_width-1:0]    data_in,
   input  logic [1:0]               access_size,
   input  logic                     rw,
   input  logic                     enable,
   output logic                     busy,
   output logic [data_width-1:0]    data_out
);

   localparam int words = depth / 4;
   localparam int index_width = (words > 1) ? $clog2(words) : 1;
   localparam logic [address_width:0] mem_bytes = (address_width+1)'(depth);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                   state;
   logic [address_width-1:0] cur_addr;
   logic [3:0]               beats_left;
   logic                     burst_rw;
   logic [data_width-1:0]    mem [words];

   logic                     accept;
   logic                     beat_active;
   logic                     beat_rw;
   logic                     beat_in_range;
   logic [address_width-1:0] beat_addr;
   logic [address_width-1:0] beat_offset;
   logic [index_width-1:0]   beat_index;
   logic [3:0]               first_beats_left;

   // The beat serviced on this edge: the incoming request when accepting in IDLE,
   // otherwise the next address of the running burst. The offset subtraction wraps,
   // so addresses below start_addr become huge and fail the single range compare.
   always_comb begin
      accept = (state == IDLE) && enable;
      beat_active = accept || (state == BURST);
      beat_addr = accept ? (address & ~address_width'(3)) : cur_addr;
      beat_rw = accept ? rw : burst_rw;
      beat_offset = beat_addr - start_addr;
      beat_in_range = {1'b0, beat_offset} < mem_bytes;
      beat_index = beat_offset[index_width+1:2];
      case (access_size)
         2'd0:    first_beats_left = 4'd0;
         2'd1:    first_beats_left = 4'd3;
         2'd2:    first_beats_left = 4'd7;
         default: first_beats_left = 4'd15;
      endcase
   end

   // Storage is never cleared; a reset edge simply suppresses the beat it lands on.
   always_ff @(posedge clock) begin
      if (!reset && beat_active && !beat_rw && beat_in_range)
         mem[beat_index] <= data_in;
   end

   // Control FSM; beats_left counts the beats still owed after the current edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         busy <= 1'b0;
         data_out <= '0;
         beats_left <= 4'd0;
         cur_addr <= '0;
         burst_rw <= 1'b0;
      end else begin
         if (beat_active && beat_rw)
            data_out <= beat_in_range ? mem[beat_index] : '0;
         if (beat_active)
            cur_addr <= beat_addr + address_width'(4);
         case (state)
            IDLE: begin
               if (enable) begin
                  burst_rw <= rw;
                  beats_left <= first_beats_left;
                  if (first_beats_left != 4'd0) begin
                     state <= BURST;
                     busy <= 1'b1;
                  end
               end
            end
            BURST: begin
               beats_left <= beats_left - 4'd1;
               if (beats_left == 4'd1) begin
                  state <= IDLE;
                  busy <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_memory_responder.sv
// Scoreboard bench for burst_memory_responder: stimulus queues expected read data,
// a monitor compares data_out one cycle after every read beat.
module tb_burst_memory_responder;

   localparam logic [31:0] START = 32'h80020000;
   localparam logic [63:0] DEPTH = 64'd1048576;

   logic        clock;
   logic        reset;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [1:0]  access_size;
   logic        rw;
   logic        enable;
   logic        busy;
   logic [31:0] data_out;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_entry_t;

   exp_entry_t  exp_q[$];
   logic        expect_valid;
   logic        expect_tag;
   logic [31:0] model_mem [int];
   int          total;
   int          bad;

   burst_memory_responder dut (
      .clock(clock),
      .reset(reset),
      .address(address),
      .data_in(data_in),
      .access_size(access_size),
      .rw(rw),
      .enable(enable),
      .busy(busy),
      .data_out(data_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] pattern(input int i);
      return 32'hA5A5_0000 + 32'(i) * 32'h0000_0111;
   endfunction

   function automatic bit in_range(input logic [31:0] a);
      return ({32'b0, a} >= {32'b0, START}) && ({32'b0, a} < ({32'b0, START} + DEPTH));
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a - START) >> 2);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!in_range(a)) return 32'd0;
      if (model_mem.exists(word_of(a))) return model_mem[word_of(a)];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic check_busy(input string name, input logic expected);
      check_output(name, {31'b0, busy}, {31'b0, expected});
   endtask

   task automatic apply_stimulus(input logic en, input logic r, input logic [31:0] a,
                                 input logic [1:0] sz, input logic [31:0] d);
      @(negedge clock);
      enable = en;
      rw = r;
      address = a;
      access_size = sz;
      data_in = d;
      expect_valid = 1'b0;
   endtask

   task automatic expect_read(input string name, input logic [31:0] value);
      exp_entry_t e;
      e.name = name;
      e.value = value;
      exp_q.push_back(e);
      expect_valid = 1'b1;
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      if (in_range(a)) model_mem[word_of(a)] = d;
   endtask

   task automatic single_write(input logic [31:0] a, input logic [31:0] d);
      apply_stimulus(1'b1, 1'b0, a, 2'd0, d);
      model_write(a, d);
   endtask

   task automatic single_read(input string name, input logic [31:0] a);
      apply_stimulus(1'b1, 1'b1, a, 2'd0, 32'd0);
      expect_read(name, model_read(a));
   endtask

   task automatic go_idle();
      apply_stimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
   endtask

   // A read beat serviced on a rising edge is due on data_out by the next falling edge.
   always @(posedge clock) expect_tag <= expect_valid;

   always @(negedge clock) begin
      exp_entry_t e;
      if (expect_tag) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty: actual=%h expected=queued_value", data_out);
         end else begin
            e = exp_q.pop_front();
            check_output(e.name, data_out, e.value);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      enable = 1'b0;
      rw = 1'b0;
      address = 32'd0;
      access_size = 2'd0;
      data_in = 32'd0;
      expect_valid = 1'b0;
      expect_tag = 1'b0;
      repeat (2) @(negedge clock);
      check_output("reset_busy", {31'b0, busy}, 32'd0);
      check_output("reset_data_out", data_out, 32'd0);
      reset = 1'b0;

      // Single write then single read of the same word.
      single_write(START, 32'hDEADBEEF);
      apply_stimulus(1'b1, 1'b1, START, 2'd0, 32'd0);
      expect_read("t1_read", 32'hDEADBEEF);
      check_busy("t1_busy_after_write", 1'b0);
      go_idle();
      check_busy("t1_busy_after_read", 1'b0);

      // Four-beat write burst; conflicting request fields during busy must be ignored.
      apply_stimulus(1'b1, 1'b0, START + 32'h10, 2'd1, 32'd1);
      model_write(START + 32'h10, 32'd1);
      for (int k = 2; k <= 4; k++) begin
         apply_stimulus(1'b1, 1'b1, START + 32'h40, 2'd3, 32'(k));
         model_write(START + 32'h10 + 32'(4 * (k - 1)), 32'(k));
         check_busy($sformatf("t2_busy_beat%0d", k - 1), 1'b1);
      end
      go_idle();
      check_busy("t2_busy_done", 1'b0);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b1, 1'b1, START + 32'h10 + 32'(4 * k), 2'd0, 32'd0);
         expect_read($sformatf("t2_read%0d", k), 32'(k + 1));
      end
      go_idle();

      // Alternating write/read on every cycle with address low bits set.
      for (int i = 0; i < 16; i++) begin
         single_write(START + 32'(4 * i) + 32'd3, pattern(i));
         apply_stimulus(1'b1, 1'b1, START + 32'(4 * i) + 32'd3, 2'd0, 32'd0);
         expect_read($sformatf("t6_read%0d", i), pattern(i));
      end
      go_idle();

      // Sixteen-beat read burst with enable toggling and a write attempt during busy.
      apply_stimulus(1'b1, 1'b1, START, 2'd3, 32'd0);
      expect_read("t3_beat0", pattern(0));
      for (int i = 1; i < 16; i++) begin
         apply_stimulus(1'(i % 2), 1'b0, START, 2'd0, 32'hBAD0_0000 + 32'(i));
         expect_read($sformatf("t3_beat%0d", i), pattern(i));
         check_busy($sformatf("t3_busy%0d", i), 1'b1);
      end
      go_idle();
      check_busy("t3_busy_done", 1'b0);
      single_read("t3_word0_untouched", START);

      // Out-of-range accesses and the top edge of memory.
      single_read("t4_below", 32'h8001FFFC);
      single_read("t4_word15", START + 32'd60);
      single_read("t4_above", 32'h80120000);
      single_write(32'h80120000, 32'h12345678);
      single_write(32'h8011FFFC, 32'hCAFEF00D);
      single_read("t4_last_word", 32'h8011FFFC);
      single_read("t4_word0_after_oor_write", START);
      apply_stimulus(1'b1, 1'b0, 32'h8011FFF8, 2'd1, 32'h11);
      model_write(32'h8011FFF8, 32'h11);
      for (int k = 1; k < 4; k++) begin
         apply_stimulus(1'b1, 1'b1, START, 2'd0, 32'h11 * 32'(k + 1));
         model_write(32'h8011FFF8 + 32'(4 * k), 32'h11 * 32'(k + 1));
         check_busy($sformatf("t4_cross_busy%0d", k), 1'b1);
      end
      go_idle();
      check_busy("t4_cross_done", 1'b0);
      single_read("t4_cross_word_m2", 32'h8011FFF8);
      single_read("t4_cross_word_m1", 32'h8011FFFC);
      single_read("t4_cross_word0", START);
      single_read("t4_cross_word1", START + 32'd4);

      // Eight-beat write burst aborted by reset on its third beat edge.
      apply_stimulus(1'b1, 1'b0, START, 2'd2, 32'h5000_0000);
      model_write(START, 32'h5000_0000);
      apply_stimulus(1'b1, 1'b1, START + 32'h100, 2'd0, 32'h5000_0001);
      model_write(START + 32'd4, 32'h5000_0001);
      check_busy("t5_busy_beat1", 1'b1);
      apply_stimulus(1'b1, 1'b1, START + 32'h100, 2'd0, 32'h5000_0002);
      reset = 1'b1;
      check_busy("t5_busy_beat2", 1'b1);
      go_idle();
      reset = 1'b0;
      check_busy("t5_busy_after_reset", 1'b0);
      check_output("t5_data_out_after_reset", data_out, 32'd0);
      for (int i = 0; i < 8; i++)
         single_read($sformatf("t5_word%0d", i), START + 32'(4 * i));
      go_idle();
      check_busy("t5_busy_final", 1'b0);

      repeat (3) go_idle();
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
